cnt_wrap_mon: RTL and testbench

CNT_WRAP_MON -- requirements
Module: cnt_wrap_mon

---
 rtl/cnt_wrap_mon.sv | 137 +++++++++++++
 tb/tb_cnt_wrap_mon.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cnt_wrap_mon.sv
// cnt_wrap_mon: watches an up/down counter, counts wraps into a saturating
// total, and announces each new total over a four-phase req/ack handshake.
// Wraps that arrive while a handshake is in flight coalesce into one
// follow-up request carrying the latest total.
// Optional: define CNT_WRAP_MON_STEP_CHECK_EN to build the illegal-step
// detector that drives step_err; otherwise step_err is tied low.
module cnt_wrap_mon #(
  parameter int CNT_W = 4,
  parameter int EVT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             dir,
  input  logic             load,
  input  logic             clr,
  input  logic             evt_ack,
  output logic             evt_req,
  output logic [EVT_W-1:0] evt_data,
  output logic [EVT_W-1:0] wrap_cnt,
  output logic             sat,
  output logic             step_err
);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  localparam logic [CNT_W-1:0] CMAX  = '1;
  localparam logic [CNT_W-1:0] CZERO = '0;
  localparam logic [EVT_W-1:0] EMAX  = '1;
  localparam logic [EVT_W-1:0] ONE_E = EVT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] prev_q;
  logic             prev_vld_q;
  logic [EVT_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic [EVT_W-1:0] evt_data_q, evt_data_d;
  logic             sat_q, sat_d;
  logic             pend_q, pend_d;
  logic             wrap_det, wrap_hit;

  // Wrap = terminal value followed by the opposite terminal in the counting
  // direction; a load cycle is a new base, never a wrap. clr discards it.
  always_comb begin
    wrap_det = 1'b0;
    if (prev_vld_q && !load) begin
      if (!dir) wrap_det = (prev_q == CMAX)  && (cnt_in == CZERO);
      else      wrap_det = (prev_q == CZERO) && (cnt_in == CMAX);
    end
    wrap_hit = wrap_det && !clr;
  end

  // Accumulator, sticky saturation, handshake FSM and coalescing flag.
  always_comb begin
    state_d    = state_q;
    evt_data_d = evt_data_q;
    pend_d     = pend_q;
    wrap_cnt_d = wrap_cnt_q;
    sat_d      = sat_q;

    if (clr) begin
      wrap_cnt_d = '0;
      sat_d      = 1'b0;
    end else if (wrap_hit && (wrap_cnt_q != EMAX)) begin
      wrap_cnt_d = wrap_cnt_q + ONE_E;
      if (wrap_cnt_d == EMAX) sat_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        // A pending wrap is dropped by clr, so it cannot raise a request then.
        if (wrap_hit || (pend_q && !clr)) begin
          state_d    = REQ;
          evt_data_d = wrap_cnt_d;
        end
      end
      REQ:     if (evt_ack)  state_d = DROP;
      DROP:    if (!evt_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (clr)                                     pend_d = 1'b0;
    else if (state_q == IDLE && state_d == REQ)  pend_d = 1'b0;
    else if (wrap_hit && state_q != IDLE)        pend_d = 1'b1;
  end

  // State registers; reset abandons any handshake in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      wrap_cnt_q <= '0;
      evt_data_q <= '0;
      sat_q      <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= cnt_in;
      prev_vld_q <= 1'b1;
      wrap_cnt_q <= wrap_cnt_d;
      evt_data_q <= evt_data_d;
      sat_q      <= sat_d;
      pend_q     <= pend_d;
    end
  end

  assign evt_req  = (state_q == REQ);
  assign evt_data = evt_data_q;
  assign wrap_cnt = wrap_cnt_q;
  assign sat      = sat_q;

`ifdef CNT_WRAP_MON_STEP_CHECK_EN
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
  logic step_err_q, step_bad;

  // Legal moves: hold, one step in the current direction, or a wrap.
  always_comb begin
    step_bad = 1'b0;
    if (prev_vld_q && !load && (cnt_in != prev_q) && !wrap_det) begin
      if (!dir) step_bad = (cnt_in != (prev_q + ONE_C));
      else      step_bad = (cnt_in != (prev_q - ONE_C));
    end
  end

  // Sticky illegal-step flag, cleared by clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           step_err_q <= 1'b0;
    else if (clr)      step_err_q <= 1'b0;
    else if (step_bad) step_err_q <= 1'b1;
  end

  assign step_err = step_err_q;
`else
  assign step_err = 1'b0;
`endif

endmodule

// File: tb/tb_cnt_wrap_mon.sv
// tb_cnt_wrap_mon: directed scenarios plus randomized traffic against a
// behavioural model; requests are scoreboarded by a separate monitor.
module tb_cnt_wrap_mon;

  localparam int CW   = 4;
  localparam int EW   = 8;
  localparam int CMAX = (1 << CW) - 1;
  localparam int EMAX = (1 << EW) - 1;
`ifdef CNT_WRAP_MON_STEP_CHECK_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic          clk, rst;
  logic [CW-1:0] cnt_in;
  logic          dir, load, clr, evt_ack;
  logic          evt_req, sat, step_err;
  logic [EW-1:0] evt_data, wrap_cnt;

  cnt_wrap_mon #(.CNT_W(CW), .EVT_W(EW)) dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .dir(dir), .load(load),
    .clr(clr), .evt_ack(evt_ack), .evt_req(evt_req), .evt_data(evt_data),
    .wrap_cnt(wrap_cnt), .sat(sat), .step_err(step_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_q[$];

  // Model: wrap total, flags, last sample and the handshake phase
  // (0 = quiet, 1 = request raised, 2 = acked, awaiting release).
  int m_total, m_prev, m_phase;
  bit m_sat, m_err, m_hp, m_pend;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_total = 0; m_prev = 0; m_phase = 0;
    m_sat = 0; m_err = 0; m_hp = 0; m_pend = 0;
  endtask

  task automatic model_edge(input int c, input bit d, input bit l, input bit cl, input bit a);
    bit w, w_eff, bad;
    int legal, ph0;
    w = m_hp && !l && ((!d && m_prev == CMAX && c == 0) || (d && m_prev == 0 && c == CMAX));
    legal = d ? (m_prev + CMAX) % (CMAX + 1) : (m_prev + 1) % (CMAX + 1);
    bad = STEP_EN && m_hp && !l && !w && (c != m_prev) && (c != legal);
    w_eff = w && !cl;
    ph0 = m_phase;
    if (cl) begin
      m_total = 0; m_sat = 0; m_err = 0; m_pend = 0;
    end else begin
      if (w_eff && m_total < EMAX) m_total++;
      if (w_eff && m_total == EMAX) m_sat = 1;
      if (bad) m_err = 1;
    end
    case (ph0)
      0: if (w_eff || m_pend) begin
           m_phase = 1;
           m_pend  = 0;
           exp_q.push_back(m_total);
         end
      1: if (a)  m_phase = 2;
      default: if (!a) m_phase = 0;
    endcase
    if (w_eff && ph0 != 0) m_pend = 1;
    m_prev = c;
    m_hp   = 1;
  endtask

  task automatic step(input int c, input bit d, input bit l, input bit cl, input bit a);
    cnt_in = c[CW-1:0]; dir = d; load = l; clr = cl; evt_ack = a;
    @(posedge clk);
    model_edge(c, d, l, cl, a);
    #1;
    check("wrap_cnt", wrap_cnt, m_total);
    check("sat", sat, m_sat);
    check("step_err", step_err, m_err);
    check("evt_req", evt_req, m_phase == 1);
  endtask

  // One up-wrap: load 15 as a base, then sample 0.
  task automatic wrap_up(input bit a);
    step(CMAX, 0, 1, 0, a);
    step(0, 0, 0, 0, a);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_evt_req", evt_req, 0);
    check("rst_evt_data", evt_data, 0);
    check("rst_wrap_cnt", wrap_cnt, 0);
    check("rst_sat", sat, 0);
    check("rst_step_err", step_err, 0);
    model_reset();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: each new request pops the expected total; data must hold while high.
  logic          seen_req = 1'b0;
  logic [EW-1:0] held;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) seen_req = 1'b0;
      else begin
        if (evt_req && !seen_req) begin
          check("evt_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) check("evt_data", evt_data, exp_q.pop_front());
          held = evt_data;
        end else if (evt_req) begin
          check("evt_data_stable", evt_data, held);
        end
        seen_req = evt_req;
      end
    end
  end

  initial begin
    int cur;
    bit d, a;
    rst = 1'b0; cnt_in = '0; dir = 0; load = 0; clr = 0; evt_ack = 0;
    model_reset();

    // Up-count wrap: 13,14,15,0,1
    do_reset();
    step(13, 0, 0, 0, 0); step(14, 0, 0, 0, 0); step(15, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("up_wrap_cnt", wrap_cnt, 1);
    check("up_evt_req", evt_req, 1);
    check("up_evt_data", evt_data, 1);
    step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 1); step(1, 0, 0, 0, 0);

    // Down-count wrap, then the same run with load on 15
    do_reset();
    step(1, 1, 0, 0, 0); step(0, 1, 0, 0, 0); step(15, 1, 0, 0, 0); step(14, 1, 0, 0, 0);
    check("down_wrap_cnt", wrap_cnt, 1);
    do_reset();
    step(1, 1, 0, 0, 0); step(0, 1, 0, 0, 0); step(15, 1, 1, 0, 0); step(14, 1, 0, 0, 0);
    check("down_load_no_wrap", wrap_cnt, 0);
    check("down_load_no_req", evt_req, 0);

    // Coalescing: four wraps with ack held low, one follow-up request
    do_reset();
    for (int i = 0; i < 4; i++) wrap_up(0);
    check("coal_wrap_cnt", wrap_cnt, 4);
    step(0, 0, 0, 0, 1); step(0, 0, 0, 0, 0);
    check("coal_idle_gap", evt_req, 0);
    step(0, 0, 0, 0, 0);
    check("coal_second_req", evt_req, 1);
    check("coal_second_data", evt_data, 4);
    step(0, 0, 0, 0, 1); step(0, 0, 0, 0, 0); step(0, 0, 0, 0, 0);
    check("coal_final_idle", evt_req, 0);

    // Saturation at 255 then clr
    do_reset();
    for (int i = 0; i < 254; i++) wrap_up(1'($urandom_range(0, 1)));
    check("sat_pre_cnt", wrap_cnt, 254);
    check("sat_pre_flag", sat, 0);
    wrap_up(0); wrap_up(0);
    check("sat_cnt", wrap_cnt, 255);
    check("sat_flag", sat, 1);
    step(0, 0, 0, 1, 0);
    check("clr_cnt", wrap_cnt, 0);
    check("clr_sat", sat, 0);

    // Illegal step 3 -> 7
    do_reset();
    step(3, 0, 0, 0, 0); step(7, 0, 0, 0, 0);
    check("step_err_set", step_err, STEP_EN);
    step(8, 0, 0, 0, 0);
    check("step_err_sticky", step_err, STEP_EN);

    // Reset mid-handshake with ack high; post-reset 0 after 15 is not a wrap
    do_reset();
    wrap_up(0);
    step(CMAX, 0, 1, 0, 0);
    evt_ack = 1'b1;
    check("mid_req_before_rst", evt_req, 1);
    do_reset();
    step(0, 0, 0, 0, 0);
    check("post_rst_no_wrap", wrap_cnt, 0);
    check("post_rst_no_req", evt_req, 0);

    // Randomized traffic
    do_reset();
    cur = 0; d = 0;
    for (int i = 0; i < 3000; i++) begin
      int r;
      bit l, cl;
      r = $urandom_range(0, 19);
      l = 0;
      if ($urandom_range(0, 49) == 0) d = ~d;
      if (r < 13)       cur = d ? (cur + CMAX) % (CMAX + 1) : (cur + 1) % (CMAX + 1);
      else if (r < 16)  cur = cur;
      else if (r < 18)  begin cur = $urandom_range(0, CMAX); l = 1; end
      else              cur = $urandom_range(0, CMAX);
      cl = ($urandom_range(0, 59) == 0);
      a  = ($urandom_range(0, 3) != 0) ? (m_phase == 1) : 1'($urandom_range(0, 1));
      step(cur, d, l, cl, a);
    end

    // Drain any outstanding handshake
    for (int i = 0; i < 12; i++) step(cur, d, 1, 0, m_phase == 1);
    check("drain_idle", evt_req, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
